piece_move_controller: RTL and testbench
========================================

Name: piece_move_controller

Overview:
- Sequential stage that consumes the collision flags from the piece collision checker and owns the active piece's position and rotation registers.
- Accepts player move pulses and the gravity tick, and applies at most one legal move per cycle.
- Runs lock delay, hands the landed piece to the board writer through a valid/ready handshake, and then requests the next spawn.
- Its piece_x, piece_y, rot and no_piece outputs feed the collision checker and piece-grid lookup directly.

Parameters:
- BOARD_WIDTH, 10, board columns; sets piece_x width to $clog2(BOARD_WIDTH).
- BOARD_HEIGHT, 20, board rows; sets piece_y width to $clog2(BOARD_HEIGHT).
- SPAWN_X, 3, piece_x loaded on spawn.
- LOCK_TICKS, 2, number of blocked gravity ticks before the piece locks (minimum 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- gravity_tick  in  1  one-cycle pulse requesting a one-row descent
- move_left / move_right / rotate_cw / hard_drop  in  1 each  one-cycle debounced button pulses
- spawn_valid  in  1  next piece is available from the piece generator
- spawn_ready  out  1  controller accepts a spawn this cycle
- left_collision / right_collision / down_collision / rotation_collision  in  1 each  combinational flags for the current outputs
- piece_x  out  $clog2(BOARD_WIDTH)  active piece column
- piece_y  out  $clog2(BOARD_HEIGHT)  active piece row
- rot  out  2  rotation index
- no_piece  out  1  high when no active piece exists
- lock_valid  out  1  request to write the piece into the board
- lock_ready  in  1  board writer accepts the lock
- game_over  out  1  sticky; set when a piece locks at piece_y == 0

Behaviour:
- Reset values: state=IDLE, piece_x=SPAWN_X, piece_y=0, rot=0, no_piece=1, spawn_ready=0, lock_valid=0, game_over=0, lock_cnt=0, grav_pend=0.
- All outputs are registered. Reset asserted mid-operation returns to reset values immediately; an in-flight lock is abandoned.
- IDLE: spawn_ready=1. When spawn_valid & spawn_ready: load piece_x=SPAWN_X, piece_y=0, rot=0, no_piece=0, lock_cnt=0, grav_pend=0; go to SETTLE.
- SETTLE: one cycle to let the downstream piece-grid lookup and the checker reflect the new registers. Collision flags are ignored here. Go to DROP if drop_mode is set, else ACTIVE.
- gravity_tick arriving in any state other than ACTIVE sets grav_pend. Button pulses arriving outside ACTIVE are discarded.
- ACTIVE: at most one action per cycle, in this priority order:
  1. rotate_cw: if !rotation_collision, rot <= rot+1 (mod 4) and go to SETTLE.
  2. move_left: if !left_collision, piece_x-1 and go to SETTLE.
  3. move_right: if !right_collision, piece_x+1 and go to SETTLE.
  4. hard_drop: set drop_mode and go to DROP.
  5. gravity (gravity_tick | grav_pend): clear grav_pend.
     - If !down_collision and piece_y < BOARD_HEIGHT-1: piece_y+1, lock_cnt=0, go to SETTLE.
     - Otherwise lock_cnt+1; when lock_cnt reaches LOCK_TICKS, go to LOCK.
- A blocked move leaves the registers unchanged and stays in ACTIVE. Any lower-priority pulse in the same cycle is discarded, except gravity, which sets grav_pend.
- DROP: if !down_collision and piece_y < BOARD_HEIGHT-1, piece_y+1 and go to SETTLE (drop_mode kept). Otherwise clear drop_mode and go to LOCK with no lock delay. Descent rate is one row per 2 cycles.
- LOCK: lock_valid=1, holding piece_x, piece_y and rot stable until lock_ready.
  - On the handshake, lock_valid=0 and no_piece=1.
  - If piece_y == 0, set game_over and go to OVER; else go to IDLE.
- OVER: terminal until reset. no_piece=1 and all inputs are ignored.
- piece_x/piece_y never wrap: a decrement at 0 or an increment at the maximum is suppressed even if the collision flag is low.

Decomposition:
- game_state_pkg: add ctrl_state_t enum {IDLE, SETTLE, ACTIVE, DROP, LOCK, OVER}, plus SPAWN_X and LOCK_TICKS defaults.
- No sub-module. The lock-delay counter stays inline.

Test Plan:
- Spawn: reset, then spawn_valid=1 → spawn_ready high in IDLE; next cycle piece_x=3, piece_y=0, rot=0, no_piece=0; ACTIVE reached 2 cycles after the handshake.
- Blocked move: left_collision=1 with move_left pulse at piece_x=3 → piece_x stays 3. With left_collision=0 → piece_x=2 one cycle later, state SETTLE.
- Simultaneous events: rotate_cw, move_right and gravity_tick in the same cycle, no collisions → rot=1 with piece_x/piece_y unchanged; the pending gravity is then applied in the next ACTIVE cycle, giving piece_y=1.
- Lock delay: down_collision=1 with LOCK_TICKS=2 → first gravity tick gives no lock; second gives lock_valid=1. With lock_ready held 0 for 3 cycles, lock_valid and the position stay stable. Once lock_ready=1 → no_piece=1, spawn_ready=1.
- Hard drop: empty board where down_collision rises at piece_y=18 → piece_y steps 0→18 over 36 cycles, then lock_valid with no lock delay.
- Game over and reset: a piece locks at piece_y=0 → game_over=1 and stays set through later spawn_valid pulses. Asserting reset while lock_valid=1 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/game_state_pkg.sv
// Shared types and default constants for the active-piece move controller.
package game_state_pkg;

  // Controller phases: wait for a spawn, let the lookup settle, accept moves,
  // hard-drop descent, hand off to the board writer, and terminal game over.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ACTIVE = 3'd2,
    DROP   = 3'd3,
    LOCK   = 3'd4,
    OVER   = 3'd5
  } ctrl_state_t;

  localparam int BOARD_WIDTH_DEFAULT  = 10;
  localparam int BOARD_HEIGHT_DEFAULT = 20;
  localparam int SPAWN_X_DEFAULT      = 3;
  localparam int LOCK_TICKS_DEFAULT   = 2;

endpackage

// File: rtl/piece_move_controller.sv
// Owns the active piece's position/rotation, applies at most one legal move
// per cycle, runs lock delay and hands the landed piece to the board writer.
module piece_move_controller
  import game_state_pkg::*;
#(
  parameter int BOARD_WIDTH  = BOARD_WIDTH_DEFAULT,
  parameter int BOARD_HEIGHT = BOARD_HEIGHT_DEFAULT,
  parameter int SPAWN_X      = SPAWN_X_DEFAULT,
  parameter int LOCK_TICKS   = LOCK_TICKS_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            gravity_tick,
  input  logic                            move_left,
  input  logic                            move_right,
  input  logic                            rotate_cw,
  input  logic                            hard_drop,
  input  logic                            spawn_valid,
  output logic                            spawn_ready,
  input  logic                            left_collision,
  input  logic                            right_collision,
  input  logic                            down_collision,
  input  logic                            rotation_collision,
  output logic [$clog2(BOARD_WIDTH)-1:0]  piece_x,
  output logic [$clog2(BOARD_HEIGHT)-1:0] piece_y,
  output logic [1:0]                      rot,
  output logic                            no_piece,
  output logic                            lock_valid,
  input  logic                            lock_ready,
  output logic                            game_over
);

  localparam int XW  = $clog2(BOARD_WIDTH);
  localparam int YW  = $clog2(BOARD_HEIGHT);
  localparam int LCW = $clog2(LOCK_TICKS + 1);

  localparam logic [XW-1:0]  X_MAX   = XW'(BOARD_WIDTH - 1);
  localparam logic [YW-1:0]  Y_MAX   = YW'(BOARD_HEIGHT - 1);
  localparam logic [XW-1:0]  X_SPAWN = XW'(SPAWN_X);
  localparam logic [LCW-1:0] LOCK_AT = LCW'(LOCK_TICKS);

  ctrl_state_t    state;
  logic [LCW-1:0] lock_cnt;
  logic           grav_pend;
  logic           drop_mode;

  logic           can_left;
  logic           can_right;
  logic           can_down;
  logic           grav_req;
  logic [LCW-1:0] lock_cnt_inc;

  // Legality of each move: collision flag low and no wrap at the board edges.
  always_comb begin
    can_left     = !left_collision  && (piece_x != '0);
    can_right    = !right_collision && (piece_x != X_MAX);
    can_down     = !down_collision  && (piece_y <  Y_MAX);
    grav_req     = gravity_tick | grav_pend;
    lock_cnt_inc = lock_cnt + 1'b1;
  end

  // Controller FSM with all outputs and piece registers held in flops.
  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // where two assignments hit the same register, the later one wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      piece_x     <= X_SPAWN;
      piece_y     <= '0;
      rot         <= '0;
      no_piece    <= 1'b1;
      spawn_ready <= 1'b0;
      lock_valid  <= 1'b0;
      game_over   <= 1'b0;
      lock_cnt    <= '0;
      grav_pend   <= 1'b0;
      drop_mode   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gravity_tick) grav_pend <= 1'b1;
          if (spawn_valid && spawn_ready) begin
            piece_x     <= X_SPAWN;
            piece_y     <= '0;
            rot         <= '0;
            no_piece    <= 1'b0;
            lock_cnt    <= '0;
            grav_pend   <= 1'b0;
            spawn_ready <= 1'b0;
            state       <= SETTLE;
          end else begin
            spawn_ready <= 1'b1;
          end
        end

        SETTLE: begin
          // Collision flags still describe the old registers here.
          if (gravity_tick) grav_pend <= 1'b1;
          state <= drop_mode ? DROP : ACTIVE;
        end

        ACTIVE: begin
          if (rotate_cw) begin
            if (gravity_tick) grav_pend <= 1'b1;
            if (!rotation_collision) begin
              rot   <= rot + 2'd1;
              state <= SETTLE;
            end
          end else if (move_left) begin
            if (gravity_tick) grav_pend <= 1'b1;
            if (can_left) begin
              piece_x <= piece_x - 1'b1;
              state   <= SETTLE;
            end
          end else if (move_right) begin
            if (gravity_tick) grav_pend <= 1'b1;
            if (can_right) begin
              piece_x <= piece_x + 1'b1;
              state   <= SETTLE;
            end
          end else if (hard_drop) begin
            if (gravity_tick) grav_pend <= 1'b1;
            drop_mode <= 1'b1;
            state     <= DROP;
          end else if (grav_req) begin
            grav_pend <= 1'b0;
            if (can_down) begin
              piece_y  <= piece_y + 1'b1;
              lock_cnt <= '0;
              state    <= SETTLE;
            end else if (lock_cnt_inc >= LOCK_AT) begin
              lock_cnt   <= lock_cnt_inc;
              lock_valid <= 1'b1;
              state      <= LOCK;
            end else begin
              lock_cnt <= lock_cnt_inc;
            end
          end
        end

        DROP: begin
          if (gravity_tick) grav_pend <= 1'b1;
          if (can_down) begin
            piece_y <= piece_y + 1'b1;
            state   <= SETTLE;
          end else begin
            drop_mode  <= 1'b0;
            lock_valid <= 1'b1;
            state      <= LOCK;
          end
        end

        LOCK: begin
          // Position and rotation are untouched until the writer accepts.
          if (gravity_tick) grav_pend <= 1'b1;
          if (lock_ready) begin
            lock_valid <= 1'b0;
            no_piece   <= 1'b1;
            if (piece_y == '0) begin
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              spawn_ready <= 1'b1;
              state       <= IDLE;
            end
          end
        end

        OVER: begin
          no_piece <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_move_controller.sv
// Directed self-checking bench for piece_move_controller.
module tb_piece_move_controller;
  import game_state_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       gravity_tick, move_left, move_right, rotate_cw, hard_drop;
  logic       spawn_valid, spawn_ready;
  logic       left_collision, right_collision, down_collision, rotation_collision;
  logic [3:0] piece_x;
  logic [4:0] piece_y;
  logic [1:0] rot;
  logic       no_piece, lock_valid, lock_ready, game_over;

  int vectors     = 0;
  int miscompares = 0;

  piece_move_controller dut (
    .clk                (clk),
    .reset              (reset),
    .gravity_tick       (gravity_tick),
    .move_left          (move_left),
    .move_right         (move_right),
    .rotate_cw          (rotate_cw),
    .hard_drop          (hard_drop),
    .spawn_valid        (spawn_valid),
    .spawn_ready        (spawn_ready),
    .left_collision     (left_collision),
    .right_collision    (right_collision),
    .down_collision     (down_collision),
    .rotation_collision (rotation_collision),
    .piece_x            (piece_x),
    .piece_y            (piece_y),
    .rot                (rot),
    .no_piece           (no_piece),
    .lock_valid         (lock_valid),
    .lock_ready         (lock_ready),
    .game_over          (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    check({tag, "_x"},     32'(piece_x), 32'd3);
    check({tag, "_y"},     32'(piece_y), 32'd0);
    check({tag, "_rot"},   32'(rot), 32'd0);
    check({tag, "_nop"},   32'(no_piece), 32'd1);
    check({tag, "_srdy"},  32'(spawn_ready), 32'd0);
    check({tag, "_lv"},    32'(lock_valid), 32'd0);
    check({tag, "_go"},    32'(game_over), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    {gravity_tick, move_left, move_right, rotate_cw, hard_drop} = '0;
    {spawn_valid, lock_ready} = '0;
    {left_collision, right_collision, down_collision, rotation_collision} = '0;

    // Reset state
    #1;
    check_reset_values("rst");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_srdy", 32'(spawn_ready), 32'd1);

    // Spawn handshake, then SETTLE, then ACTIVE
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    check("spawn_state", 32'(dut.state), 32'(SETTLE));
    check("spawn_x",     32'(piece_x), 32'd3);
    check("spawn_y",     32'(piece_y), 32'd0);
    check("spawn_rot",   32'(rot), 32'd0);
    check("spawn_nop",   32'(no_piece), 32'd0);
    check("spawn_srdy",  32'(spawn_ready), 32'd0);
    tick();
    check("active_state", 32'(dut.state), 32'(ACTIVE));

    // Blocked left move
    left_collision = 1'b1;
    move_left      = 1'b1;
    tick();
    move_left      = 1'b0;
    left_collision = 1'b0;
    check("blk_left_x",  32'(piece_x), 32'd3);
    check("blk_left_st", 32'(dut.state), 32'(ACTIVE));

    // Legal left move
    move_left = 1'b1;
    tick();
    move_left = 1'b0;
    check("left_x",  32'(piece_x), 32'd2);
    check("left_st", 32'(dut.state), 32'(SETTLE));
    tick();

    // Rotate + move_right + gravity in one cycle: rotate wins, gravity deferred
    rotate_cw    = 1'b1;
    move_right   = 1'b1;
    gravity_tick = 1'b1;
    tick();
    {rotate_cw, move_right, gravity_tick} = '0;
    check("sim_rot", 32'(rot), 32'd1);
    check("sim_x",   32'(piece_x), 32'd2);
    check("sim_y",   32'(piece_y), 32'd0);
    tick();
    check("sim_active", 32'(dut.state), 32'(ACTIVE));
    tick();
    check("pend_y",  32'(piece_y), 32'd1);
    check("pend_st", 32'(dut.state), 32'(SETTLE));
    tick();

    // Walk to the left edge, then a left move at column 0 is suppressed
    for (int i = 0; i < 2; i++) begin
      move_left = 1'b1;
      tick();
      move_left = 1'b0;
      tick();
    end
    check("edge_x", 32'(piece_x), 32'd0);
    move_left = 1'b1;
    tick();
    move_left = 1'b0;
    check("nowrap_x",  32'(piece_x), 32'd0);
    check("nowrap_st", 32'(dut.state), 32'(ACTIVE));

    // Lock delay: two blocked gravity ticks
    down_collision = 1'b1;
    gravity_tick   = 1'b1;
    tick();
    gravity_tick = 1'b0;
    check("ld1_lv", 32'(lock_valid), 32'd0);
    check("ld1_st", 32'(dut.state), 32'(ACTIVE));
    gravity_tick = 1'b1;
    tick();
    gravity_tick = 1'b0;
    check("ld2_lv", 32'(lock_valid), 32'd1);
    check("ld2_st", 32'(dut.state), 32'(LOCK));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_lv",  32'(lock_valid), 32'd1);
      check("hold_x",   32'(piece_x), 32'd0);
      check("hold_y",   32'(piece_y), 32'd1);
      check("hold_rot", 32'(rot), 32'd1);
    end
    lock_ready = 1'b1;
    tick();
    lock_ready     = 1'b0;
    down_collision = 1'b0;
    check("hs_lv",   32'(lock_valid), 32'd0);
    check("hs_nop",  32'(no_piece), 32'd1);
    check("hs_srdy", 32'(spawn_ready), 32'd1);
    check("hs_go",   32'(game_over), 32'd0);

    // Hard drop on an empty board, floor detected at row 18
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    tick();
    hard_drop = 1'b1;
    tick();
    hard_drop = 1'b0;
    check("hd_st", 32'(dut.state), 32'(DROP));
    for (int k = 1; k <= 18; k++) begin
      tick();
      check("hd_step_y", 32'(piece_y), 32'(k));
      tick();
    end
    check("hd_at18_st", 32'(dut.state), 32'(DROP));
    down_collision = 1'b1;
    tick();
    check("hd_lv", 32'(lock_valid), 32'd1);
    check("hd_y",  32'(piece_y), 32'd18);
    lock_ready = 1'b1;
    tick();
    lock_ready     = 1'b0;
    down_collision = 1'b0;
    check("hd_nop", 32'(no_piece), 32'd1);

    // Lock at row 0 -> game over, sticky through spawn offers
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    tick();
    down_collision = 1'b1;
    for (int i = 0; i < 2; i++) begin
      gravity_tick = 1'b1;
      tick();
      gravity_tick = 1'b0;
    end
    check("go_lv", 32'(lock_valid), 32'd1);
    lock_ready = 1'b1;
    tick();
    lock_ready = 1'b0;
    check("go_set", 32'(game_over), 32'd1);
    spawn_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    spawn_valid = 1'b0;
    check("go_sticky", 32'(game_over), 32'd1);
    check("go_srdy",   32'(spawn_ready), 32'd0);
    check("go_nop",    32'(no_piece), 32'd1);
    check("go_st",     32'(dut.state), 32'(OVER));

    // Reset clears game over
    reset = 1'b1;
    #1;
    check_reset_values("rst2");
    tick();
    reset = 1'b0;
    tick();

    // Reset asserted mid-cycle during an in-flight lock
    spawn_valid = 1'b1;
    tick();
    spawn_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      gravity_tick = 1'b1;
      tick();
      gravity_tick = 1'b0;
    end
    check("inflight_lv", 32'(lock_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
